// File: rtl/full_handshake_rx_fifo.sv
// ---------------------------------------------------------------------------
// full_handshake_rx_fifo
//
// Receive side of a four-phase req/ack clock-domain-crossing handshake.
// The asynchronous TX request is synchronised into the clk domain. Each
// request rising edge captures one word into a DEPTH-entry
// first-word-fall-through FIFO. The word is acknowledged only when the FIFO
// has room, so the TX side sees real backpressure.
//
// Handshake rules:
//   TX side : TX holds req_data_i stable from before req_i rises until ack_o
//             is seen. ack_o rises once the word is stored. It falls once
//             req_i has been seen low again.
//   RX side : recv_valid_o/recv_ready_i is a plain valid/ready stream. The
//             head word transfers on every clk edge where both are high.
//             recv_valid_o does not depend on recv_ready_i. recv_ready_i
//             may stay high while recv_valid_o is low; that has no effect.
//
// Ports:
//   clk           RX-domain clock
//   rst           synchronous, active-high reset
//   req_i         TX request (asynchronous to clk)
//   req_data_i    TX data word
//   ack_o         registered acknowledge to TX
//   recv_data_o   head-of-FIFO word (don't-care while empty)
//   recv_valid_o  FIFO non-empty
//   recv_ready_i  consumer accepts the head word
//   fifo_count_o  occupancy, 0..DEPTH
//
// The FSM state is held in `state`, a one-hot vector that checkers can
// probe: IDLE=001, WAIT_SPACE=010, DEASSERT=100.
// ---------------------------------------------------------------------------
module full_handshake_rx_fifo #(
    parameter int DW          = 32,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_i,
    input  logic [DW-1:0]            req_data_i,
    output logic                     ack_o,
    output logic [DW-1:0]            recv_data_o,
    output logic                     recv_valid_o,
    input  logic                     recv_ready_i,
    output logic [$clog2(DEPTH):0]   fifo_count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    localparam logic [2:0] IDLE       = 3'b001;
    localparam logic [2:0] WAIT_SPACE = 3'b010;
    localparam logic [2:0] DEASSERT   = 3'b100;

    // ------------------------------------------------------------------
    // Request synchroniser
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], req_i};
        end
    end

    assign req_s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // FIFO status
    // ------------------------------------------------------------------
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          pop;
    logic          space;
    logic          push;

    assign full  = (count == FULL_COUNT);
    assign pop   = recv_valid_o & recv_ready_i;
    // A pop in this same cycle frees the slot that the push will fill.
    assign space = !full | pop;

    // ------------------------------------------------------------------
    // Handshake FSM
    // ------------------------------------------------------------------
    logic [2:0] state;
    logic [2:0] state_next;
    logic       ack_next;

    always_comb begin
        state_next = state;
        ack_next   = ack_o;
        push       = 1'b0;
        case (state)
            IDLE: begin
                if (req_s) begin
                    if (space) begin
                        push       = 1'b1;
                        ack_next   = 1'b1;
                        state_next = DEASSERT;
                    end else begin
                        state_next = WAIT_SPACE;
                    end
                end
            end
            WAIT_SPACE: begin
                // A request withdrawn before it was acknowledged is dropped.
                if (!req_s) begin
                    state_next = IDLE;
                end else if (space) begin
                    push       = 1'b1;
                    ack_next   = 1'b1;
                    state_next = DEASSERT;
                end
            end
            DEASSERT: begin
                // Hold ack until TX drops req. This gives exactly one push
                // per req rising edge.
                if (!req_s) begin
                    ack_next   = 1'b0;
                    state_next = IDLE;
                end
            end
            default: begin
                ack_next   = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ack_o <= 1'b0;
        end else begin
            state <= state_next;
            ack_o <= ack_next;
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------
    // The storage has no reset. Its contents only matter when count > 0.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= req_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign recv_data_o  = mem[rd_ptr];
    assign recv_valid_o = (count != '0);
    assign fifo_count_o = count;

endmodule

// File: tb/tb_full_handshake_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_full_handshake_rx_fifo
//
// Directed bench for full_handshake_rx_fifo with DW=32, DEPTH=4 and
// SYNC_STAGES=2. Each word issued to the TX side is pushed into exp_q. A
// separate monitor pops exp_q and compares it on every accepted RX beat.
// Directed checks cover ack timing, occupancy and FSM state.
// ---------------------------------------------------------------------------
module tb_full_handshake_rx_fifo;

    localparam int DW = 32;
    localparam logic [2:0] S_IDLE       = 3'b001;
    localparam logic [2:0] S_WAIT_SPACE = 3'b010;
    localparam logic [2:0] S_DEASSERT   = 3'b100;

    logic          clk;
    logic          rst;
    logic          req;
    logic [DW-1:0] req_data;
    logic          ack;
    logic [DW-1:0] recv_data;
    logic          recv_valid;
    logic          recv_ready;
    logic [2:0]    fifo_count;

    logic [DW-1:0] exp_q[$];
    int            n_vec;
    int            n_fail;
    logic          track;
    int            max_cnt;

    full_handshake_rx_fifo #(.DW(DW), .DEPTH(4), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_i        (req),
        .req_data_i   (req_data),
        .ack_o        (ack),
        .recv_data_o  (recv_data),
        .recv_valid_o (recv_valid),
        .recv_ready_i (recv_ready),
        .fifo_count_o (fifo_count)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Generic comparison
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: it samples on the falling edge, so the beat seen
    // here is the one the next rising edge accepts.
    always @(negedge clk) begin
        if (!rst && recv_valid === 1'b1 && recv_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL rx_unexpected: got %0h with no word expected", recv_data);
            end else begin
                check("rx_data", {32'd0, recv_data}, {32'd0, exp_q.pop_front()});
            end
        end
        if (track && int'(fifo_count) > max_cnt) begin
            max_cnt = int'(fifo_count);
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input logic lvl, input string name);
        int n;
        n = 0;
        while (ack !== lvl && n < 30) begin
            @(negedge clk);
            n++;
        end
        check(name, {63'd0, ack}, {63'd0, lvl});
    endtask

    task automatic xfer(input logic [DW-1:0] d);
        req_data = d;
        req      = 1'b1;
        exp_q.push_back(d);
        wait_ack(1'b1, "ack_rise");
        req = 1'b0;
        wait_ack(1'b0, "ack_fall");
    endtask

    task automatic drain();
        int n;
        n = 0;
        recv_ready = 1'b1;
        while (fifo_count !== 3'd0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("drain_count", {61'd0, fifo_count}, 64'd0);
        recv_ready = 1'b0;
        @(negedge clk);
    endtask

    logic ack_seen;

    initial begin
        n_vec      = 0;
        n_fail     = 0;
        track      = 1'b0;
        max_cnt    = 0;
        rst        = 1'b1;
        req        = 1'b0;
        req_data   = '0;
        recv_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("reset_ack",   {63'd0, ack},        64'd0);
        check("reset_valid", {63'd0, recv_valid}, 64'd0);
        check("reset_count", {61'd0, fifo_count}, 64'd0);
        check("reset_state", {61'd0, dut.state},  {61'd0, S_IDLE});

        // Single transfer latency
        tick();
        req_data = 32'hA5A5_0001;
        req      = 1'b1;
        exp_q.push_back(32'hA5A5_0001);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("lat_ack_edge2",   {63'd0, ack},        64'd0);
        check("lat_valid_edge2", {63'd0, recv_valid}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("lat_ack_edge3",   {63'd0, ack},        64'd1);
        check("lat_valid_edge3", {63'd0, recv_valid}, 64'd1);
        check("lat_data",        {32'd0, recv_data},  64'hA5A5_0001);
        tick();
        req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("fall_ack_edge2", {63'd0, ack}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        check("fall_ack_edge3", {63'd0, ack}, 64'd0);
        check("single_count",   {61'd0, fifo_count}, 64'd1);
        drain();

        // Fill, then backpressure
        for (int i = 0; i < 4; i++) begin
            xfer(32'h10 + 32'(i));
        end
        check("fill_count", {61'd0, fifo_count}, 64'd4);
        req_data = 32'h14;
        req      = 1'b1;
        exp_q.push_back(32'h14);
        repeat (6) @(negedge clk);
        check("bp_ack",   {63'd0, ack},        64'd0);
        check("bp_state", {61'd0, dut.state},  {61'd0, S_WAIT_SPACE});
        check("bp_count", {61'd0, fifo_count}, 64'd4);
        @(posedge clk);
        #1 recv_ready = 1'b1;
        @(posedge clk);
        #1 recv_ready = 1'b0;
        @(negedge clk);
        check("bp_ack_after_pop", {63'd0, ack},        64'd1);
        check("bp_count_after",   {61'd0, fifo_count}, 64'd4);
        check("bp_head_after",    {32'd0, recv_data},  64'h11);
        req = 1'b0;
        wait_ack(1'b0, "bp_ack_fall");
        drain();

        // Wrap-around with the consumer always ready
        recv_ready = 1'b1;
        max_cnt    = 0;
        track      = 1'b1;
        for (int i = 0; i < 10; i++) begin
            xfer(32'(i));
        end
        drain();
        track = 1'b0;
        check("wrap_max_count", 64'(max_cnt), 64'd1);

        // Push and pop in the same cycle at count=2
        xfer(32'hB0);
        xfer(32'hB1);
        check("pp_count_pre", {61'd0, fifo_count}, 64'd2);
        tick();
        req_data = 32'hB2;
        req      = 1'b1;
        exp_q.push_back(32'hB2);
        @(posedge clk);
        @(posedge clk);
        #1 recv_ready = 1'b1;
        @(posedge clk);
        #1 recv_ready = 1'b0;
        @(negedge clk);
        check("pp_ack",   {63'd0, ack},        64'd1);
        check("pp_count", {61'd0, fifo_count}, 64'd2);
        check("pp_head",  {32'd0, recv_data},  64'hB1);
        req = 1'b0;
        wait_ack(1'b0, "pp_ack_fall");
        drain();

        // Reset while in DEASSERT with count=3
        xfer(32'h20);
        xfer(32'h21);
        req_data = 32'h22;
        req      = 1'b1;
        exp_q.push_back(32'h22);
        wait_ack(1'b1, "rst_ack_rise");
        check("rst_pre_count", {61'd0, fifo_count}, 64'd3);
        check("rst_pre_state", {61'd0, dut.state},  {61'd0, S_DEASSERT});
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        exp_q.push_back(32'h22);
        @(negedge clk);
        check("rst_ack",   {63'd0, ack},        64'd0);
        check("rst_valid", {63'd0, recv_valid}, 64'd0);
        check("rst_count", {61'd0, fifo_count}, 64'd0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("recap_count_edge2", {61'd0, fifo_count}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("recap_count_edge3", {61'd0, fifo_count}, 64'd1);
        check("recap_ack",         {63'd0, ack},        64'd1);
        req = 1'b0;
        wait_ack(1'b0, "recap_ack_fall");
        drain();

        // Request withdrawn while waiting for space
        for (int i = 0; i < 4; i++) begin
            xfer(32'h30 + 32'(i));
        end
        req_data = 32'h55;
        req      = 1'b1;
        ack_seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            ack_seen = ack_seen | ack;
        end
        check("pv_state_wait", {61'd0, dut.state}, {61'd0, S_WAIT_SPACE});
        req = 1'b0;
        repeat (5) begin
            @(negedge clk);
            ack_seen = ack_seen | ack;
        end
        check("pv_state_idle", {61'd0, dut.state},  {61'd0, S_IDLE});
        check("pv_ack_never",  {63'd0, ack_seen},   64'd0);
        check("pv_count",      {61'd0, fifo_count}, 64'd4);
        drain();

        check("exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
